// File: rtl/value_to_bcd.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | value_to_bcd: falling-edge shift-and-add-3 binary to packed BCD       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module value_to_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam int c_bcd_w = 4 * DIGITS;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_shift, w_shift_nxt;
  logic [WIDTH-1:0]     r_last, w_last_nxt;
  logic [c_bcd_w-1:0]   r_scratch, w_scratch_nxt;
  logic [c_cnt_w-1:0]   r_count, w_count_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [c_bcd_w-1:0]   r_bcd, w_bcd_nxt;

  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_scratch_sh;
  logic [WIDTH-1:0]     w_shift_sh;
  logic                 w_req;
  logic                 w_unused_msb;

  // Digits >= 5 get +3 before the shift so they carry correctly into the next decade.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ? r_scratch[4*g +: 4] + 4'd3
                                                           : r_scratch[4*g +: 4];
  end

  assign w_scratch_sh = {w_adj[c_bcd_w-2:0], r_shift[WIDTH-1]};
  assign w_shift_sh   = {r_shift[WIDTH-2:0], 1'b0};
  assign w_unused_msb = w_adj[c_bcd_w-1];
  assign w_req        = start | (auto_en & (value != r_last));

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_last_nxt    = r_last;
    w_scratch_nxt = r_scratch;
    w_count_nxt   = r_count;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_bcd_nxt     = r_bcd;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_shift_nxt   = value;
          w_last_nxt    = value;
          w_scratch_nxt = '0;
          w_count_nxt   = c_cnt_w'(WIDTH);
          w_busy_nxt    = 1'b1;
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        w_scratch_nxt = w_scratch_sh;
        w_shift_nxt   = w_shift_sh;
        w_count_nxt   = r_count - c_cnt_w'(1);
        if (r_count == c_cnt_w'(1)) begin
          w_bcd_nxt   = w_scratch_sh;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State advances on the falling edge to line up with the incrementor stage.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_last    <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_last    <= w_last_nxt;
      r_scratch <= w_scratch_nxt;
      r_count   <= w_count_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_bcd     <= w_bcd_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_value_to_bcd.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_value_to_bcd: directed self-checking bench for value_to_bcd        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_value_to_bcd;

  logic        clk;
  logic        clr;
  logic        start;
  logic        auto_en;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [39:0] bcd;

  int checks   = 0;
  int failures = 0;
  logic [39:0] exp_prev;

  value_to_bcd #(.WIDTH(32), .DIGITS(10)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .auto_en (auto_en),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk); #1;
      if (done) cnt++;
    end
  endtask

  // Start pulse, then latency, held-output, result and pulse-width checks.
  task automatic run_conv(input string tag, input logic [31:0] v, input logic [39:0] exp);
    int n;
    @(posedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk); #1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk); #1;
      n++;
      if (n == 16) chk({tag, "_hold"}, 64'(bcd), 64'(exp_prev));
    end
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_bcd"}, 64'(bcd), 64'(exp));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    exp_prev = exp;
  endtask

  task automatic auto_step(input string tag, input logic [31:0] v, input logic [39:0] exp);
    int cnt;
    @(posedge clk);
    value = v;
    count_done(40, cnt);
    chk({tag, "_n"}, 64'(cnt), 64'd1);
    chk({tag, "_bcd"}, 64'(bcd), 64'(exp));
    exp_prev = exp;
  endtask

  initial begin
    int cnt;
    clr = 1'b1; start = 1'b0; auto_en = 1'b0; value = 32'd0;
    exp_prev = 40'h0;
    #10 clr = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd",  64'(bcd),  64'd0);
    count_done(10, cnt);
    chk("rst_quiet", 64'(cnt), 64'd0);
    chk("rst_quiet_busy", 64'(busy), 64'd0);

    run_conv("c3",   32'd3,          40'h0000000003);
    run_conv("cmax", 32'hFFFFFFFF,   40'h4294967295);
    run_conv("c999", 32'd999,        40'h0000000999);
    run_conv("c0",   32'd0,          40'h0000000000);

    // Second start while busy must be dropped.
    @(posedge clk);
    value = 32'd12; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    value = 32'd99; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    count_done(60, cnt);
    chk("busy_n", 64'(cnt), 64'd1);
    chk("busy_bcd", 64'(bcd), 64'h12);
    chk("busy_idle", 64'(busy), 64'd0);
    exp_prev = 40'h12;

    // Asynchronous abort mid-conversion.
    @(posedge clk);
    value = 32'd123456; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_busy_pre", 64'(busy), 64'd1);
    #1 clr = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bcd",  64'(bcd),  64'd0);
    @(negedge clk);
    @(posedge clk);
    clr = 1'b0;
    exp_prev = 40'h0;
    #1;
    chk("abort_hold", 64'(busy), 64'd0);
    run_conv("c7", 32'd7, 40'h7);

    // Auto mode: each value change triggers exactly one conversion.
    auto_en = 1'b1;
    auto_step("auto0", 32'd0, 40'h0);
    auto_step("auto3", 32'd3, 40'h3);
    auto_step("auto6", 32'd6, 40'h6);
    count_done(100, cnt);
    chk("auto_hold_n", 64'(cnt), 64'd0);
    chk("auto_hold_bcd", 64'(bcd), 64'h6);

    // Change mid-conversion is picked up once back in IDLE.
    @(posedge clk);
    value = 32'd21;
    repeat (5) @(negedge clk);
    @(posedge clk);
    value = 32'd45;
    count_done(80, cnt);
    chk("auto_mid_n", 64'(cnt), 64'd2);
    chk("auto_mid_bcd", 64'(bcd), 64'h45);
    auto_en = 1'b0;

    // Start held high: one conversion every 33 edges.
    @(posedge clk);
    value = 32'd2024; start = 1'b1;
    count_done(99, cnt);
    @(posedge clk);
    start = 1'b0;
    chk("b2b_n", 64'(cnt), 64'd3);
    chk("b2b_bcd", 64'(bcd), 64'h2024);
    count_done(40, cnt);
    chk("b2b_stop", 64'(cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
